wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single peripheral-side bus (wishbone_decoder input) among NUM_MANAGERS managers: mgmt SoC plus team-side DMA/CPU masters.
- Grant is held for a whole manager bus cycle (CYC high), so locked/burst transfers are never split.
- A bus watchdog terminates transfers that a peripheral never ACKs, so one hung team design cannot stall the mgmt SoC.

Parameters:
- NUM_MANAGERS, 2, number of requesting managers (>=1); index 0 wins reset-time ties.
- TIMEOUT_CYCLES, 255, cycles of STB_O high without ACK_I before forced termination; 0 disables the watchdog.
- TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned to a manager on timeout.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- A_ADR_I  in  32*NUM_MANAGERS  manager addresses, manager m at [32m+:32]
- A_DAT_I  in  32*NUM_MANAGERS  manager write data
- A_SEL_I  in  4*NUM_MANAGERS  byte selects
- A_WE_I  in  NUM_MANAGERS  write enables
- A_STB_I  in  NUM_MANAGERS  strobes
- A_CYC_I  in  NUM_MANAGERS  cycle / bus request
- A_DAT_O  out  32*NUM_MANAGERS  read data per manager
- A_ACK_O  out  NUM_MANAGERS  ack per manager
- DAT_I  in  32  peripheral read data
- ACK_I  in  1  peripheral ack
- ADR_O  out  32  muxed address
- DAT_O  out  32  muxed write data
- SEL_O  out  4  muxed byte selects
- WE_O  out  1  muxed write enable
- STB_O  out  1  muxed strobe
- CYC_O  out  1  muxed cycle
- grant_o  out  NUM_MANAGERS  one-hot current grant (debug / LA)
- timeout_o  out  1  one-cycle pulse on watchdog termination

Behaviour:
- Single clock wb_clk_i; reset wb_rst_i is synchronous, active-high.
- Reset values:
  - State IDLE, grant_o=0, last-grant pointer = NUM_MANAGERS-1 (so manager 0 has first priority).
  - Watchdog counter=0, timeout_o=0.
  - All muxed outputs 0, A_ACK_O=0, A_DAT_O=0.
- FSM states: IDLE, GRANT, TMO.
- IDLE:
  - Bus outputs are 0.
  - On a clock edge with any A_CYC_I set, select the first requester after the last-grant pointer in ascending circular order.
  - Load grant_o (one-hot), update the pointer, go to GRANT.
  - Arbitration latency is exactly 1 cycle from A_CYC_I rise to CYC_O rise.
- GRANT (g = granted index):
  - ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O are combinational copies of manager g's inputs.
  - A_ACK_O[g]=ACK_I and A_DAT_O[g]=DAT_I. Other managers see ACK=0 and DAT=0.
  - When A_CYC_I[g]=0 at a clock edge, go to IDLE and clear grant_o. This gives a mandatory one-cycle dead bus between owners.
  - Requests from other managers during GRANT are ignored until IDLE.
- Watchdog (only when TIMEOUT_CYCLES≠0):
  - Counter increments each GRANT cycle with STB_O=1 and ACK_I=0.
  - It clears on ACK_I=1, on STB_O=0, and on leaving GRANT.
  - It saturates, with no wrap.
  - When the counter reaches TIMEOUT_CYCLES with ACK_I still 0, go to TMO.
- TMO (exactly 1 cycle):
  - CYC_O=STB_O=0 (peripheral transfer abandoned).
  - A_ACK_O[g]=1 and A_DAT_O[g]=TIMEOUT_DATA.
  - timeout_o=1; counter cleared.
  - Next state is GRANT if A_CYC_I[g]=1, else IDLE.
  - A late ACK_I arriving in TMO is discarded.
- Simultaneous events:
  - ACK_I=1 in the same cycle the counter would hit the limit: the ACK wins, and there is no timeout.
  - A_CYC_I[g] falling in the same cycle as the timeout: TMO still issues its ack, then goes to IDLE.
- NUM_MANAGERS=1: the grant is always index 0, and the pointer logic reduces to a constant.
- Reset asserted mid-transfer: on the next edge the FSM returns to IDLE and all outputs take their reset values. No ack is generated for the aborted transfer.

Test Plan:
- Single manager: M0 CYC/STB read at 0x3000_0004, peripheral ACK after 2 cycles with 0x1234_5678 -> CYC_O rises 1 cycle after A_CYC_I[0]; A_ACK_O[0]=1 with A_DAT_O[0]=0x1234_5678; A_ACK_O[1]=0.
- Contention: M0 and M1 both raise CYC in the same cycle after reset -> M0 granted first (grant_o=01). After M0 drops CYC: 1 idle cycle, then grant_o=10.
- Fairness: M0 and M1 both request continuously for 6 single-beat transactions -> grant order 0,1,0,1,0,1 with one dead cycle between grants.
- Hold for burst: M1 keeps CYC high across 4 STB/ACK beats while M0 requests -> grant_o stays 10 for all 4 beats; M0 is granted only after M1 drops CYC.
- Watchdog with TIMEOUT_CYCLES=4: M0 write, ACK_I held 0 -> CYC_O/STB_O deassert after 4 stalled cycles. A_ACK_O[0] pulses with A_DAT_O[0]=0xDEADBEEF and timeout_o pulses once. ACK_I arriving on cycle 4 instead -> normal ack, no timeout_o.
- Reset mid-transfer: assert wb_rst_i while GRANT with STB_O=1 -> the next cycle shows CYC_O=0, grant_o=0, A_ACK_O=0. The first request after reset goes to M0.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//   Round-robin Wishbone arbiter. NUM_MANAGERS managers share one peripheral
//   bus. A manager keeps the grant for its whole bus cycle (CYC high), so
//   bursts and locked sequences are never split. There is one dead bus cycle
//   between owners. A watchdog ends a transfer that the peripheral never
//   acknowledges. The stalled manager then gets an ack carrying
//   TIMEOUT_DATA, so a hung peripheral cannot stall every other manager.
//
// Ports
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   A_ADR_I/A_DAT_I/A_SEL_I  manager-side request fields, manager m at
//   A_WE_I/A_STB_I/A_CYC_I   slice [W*m +: W]
//   A_DAT_O/A_ACK_O          per-manager read data / ack
//   DAT_I/ACK_I              peripheral read data / ack
//   ADR_O..CYC_O             muxed peripheral-side request
//   grant_o                  one-hot current owner (debug)
//   timeout_o                one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
   parameter int          NUM_MANAGERS   = 2,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   input  logic [32*NUM_MANAGERS-1:0]  A_ADR_I,
   input  logic [32*NUM_MANAGERS-1:0]  A_DAT_I,
   input  logic [4*NUM_MANAGERS-1:0]   A_SEL_I,
   input  logic [NUM_MANAGERS-1:0]     A_WE_I,
   input  logic [NUM_MANAGERS-1:0]     A_STB_I,
   input  logic [NUM_MANAGERS-1:0]     A_CYC_I,
   output logic [32*NUM_MANAGERS-1:0]  A_DAT_O,
   output logic [NUM_MANAGERS-1:0]     A_ACK_O,
   input  logic [31:0]                 DAT_I,
   input  logic                        ACK_I,
   output logic [31:0]                 ADR_O,
   output logic [31:0]                 DAT_O,
   output logic [3:0]                  SEL_O,
   output logic                        WE_O,
   output logic                        STB_O,
   output logic                        CYC_O,
   output logic [NUM_MANAGERS-1:0]     grant_o,
   output logic                        timeout_o
);

   localparam int PW = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(NUM_MANAGERS - 1);
   // Counter value on the stalled cycle that completes the timeout window.
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TMO} state_t;

   state_t                  state_q, state_d;
   logic [NUM_MANAGERS-1:0] grant_q, grant_d;
   // Last-grant pointer. It also selects the current owner while a grant is held.
   logic [PW-1:0]           ptr_q, ptr_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    timeout_q, timeout_d;

   // Per-manager views of the packed request buses.
   logic [31:0] adr_m [NUM_MANAGERS];
   logic [31:0] wdat_m [NUM_MANAGERS];
   logic [3:0]  sel_m [NUM_MANAGERS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MANAGERS; gi++) begin : g_mgr
         assign adr_m[gi]  = A_ADR_I[32*gi +: 32];
         assign wdat_m[gi] = A_DAT_I[32*gi +: 32];
         assign sel_m[gi]  = A_SEL_I[4*gi +: 4];

         // Only the owner ever sees ack/data. In TMO the owner gets the
         // synthetic ack and any late ACK_I is ignored.
         assign A_ACK_O[gi] = grant_q[gi] &
                              (((state_q == S_GRANT) & ACK_I) | (state_q == S_TMO));
         assign A_DAT_O[32*gi +: 32] = !grant_q[gi]         ? 32'h0 :
                                       (state_q == S_TMO)   ? TIMEOUT_DATA :
                                       (state_q == S_GRANT) ? DAT_I : 32'h0;
      end
   endgenerate

   // Round-robin pick: scan from ptr+N down to ptr+1. The last hit is the
   // nearest requester after the pointer, so it wins.
   logic          req_any;
   logic [PW-1:0] pick_idx;
   always_comb begin
      int idx;
      idx      = 0;
      req_any  = 1'b0;
      pick_idx = '0;
      for (int k = NUM_MANAGERS; k >= 1; k--) begin
         idx = (int'(ptr_q) + k) % NUM_MANAGERS;
         if (A_CYC_I[PW'(idx)]) begin
            pick_idx = PW'(idx);
            req_any  = 1'b1;
         end
      end
   end

   logic cyc_g;
   logic stb_g;
   logic stalled;
   assign cyc_g   = A_CYC_I[ptr_q];
   assign stb_g   = A_STB_I[ptr_q];
   assign stalled = (state_q == S_GRANT) & stb_g & ~ACK_I;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (req_any) begin
               state_d           = S_GRANT;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               ptr_d             = pick_idx;
            end
         end
         S_GRANT: begin
            // The watchdog is checked before the CYC drop. A timeout on the
            // cycle CYC falls therefore still produces its TMO ack.
            if ((TIMEOUT_CYCLES != 0) && stalled && (cnt_q == CNT_LAST)) begin
               state_d   = S_TMO;
               cnt_d     = '0;
               timeout_d = 1'b1;
            end else if (!cyc_g) begin
               state_d = S_IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if ((TIMEOUT_CYCLES != 0) && stalled) begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = '0;
            end
         end
         S_TMO: begin
            cnt_d = '0;
            if (cyc_g) begin
               state_d = S_GRANT;
            end else begin
               state_d = S_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         ptr_q     <= LAST_IDX;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Bus mux: a live copy of the owner during GRANT and all zero otherwise.
   // In TMO the peripheral transfer is abandoned, so the bus is zero there too.
   always_comb begin
      ADR_O = 32'h0;
      DAT_O = 32'h0;
      SEL_O = 4'h0;
      WE_O  = 1'b0;
      STB_O = 1'b0;
      CYC_O = 1'b0;
      if (state_q == S_GRANT) begin
         ADR_O = adr_m[ptr_q];
         DAT_O = wdat_m[ptr_q];
         SEL_O = sel_m[ptr_q];
         WE_O  = A_WE_I[ptr_q];
         STB_O = stb_g;
         CYC_O = cyc_g;
      end
   end

   assign grant_o   = grant_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
//   Bench for wb_rr_arbiter with two managers and a 4-cycle watchdog.
//   Each table row is one clock cycle of stimulus together with the outputs
//   expected during that cycle. Rows are driven after a rising edge and
//   checked on the following falling edge through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;

   localparam int          N    = 2;
   localparam logic [31:0] ADR0 = 32'h3000_0004;
   localparam logic [31:0] ADR1 = 32'h3000_1008;
   localparam logic [31:0] WD0  = 32'h0000_A0A0;
   localparam logic [31:0] WD1  = 32'h0000_B1B1;
   localparam logic [3:0]  SEL0 = 4'hF;
   localparam logic [3:0]  SEL1 = 4'h3;
   localparam logic [31:0] TDAT = 32'hDEAD_BEEF;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i;
   logic [63:0]   A_ADR_I, A_DAT_I, A_DAT_O;
   logic [7:0]    A_SEL_I;
   logic [1:0]    A_WE_I, A_STB_I, A_CYC_I, A_ACK_O, grant_o;
   logic [31:0]   DAT_I, ADR_O, DAT_O;
   logic          ACK_I, WE_O, STB_O, CYC_O, timeout_o;
   logic [3:0]    SEL_O;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_rr_arbiter #(
      .NUM_MANAGERS   (N),
      .TIMEOUT_CYCLES (4),
      .TIMEOUT_DATA   (TDAT)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .A_ADR_I   (A_ADR_I),
      .A_DAT_I   (A_DAT_I),
      .A_SEL_I   (A_SEL_I),
      .A_WE_I    (A_WE_I),
      .A_STB_I   (A_STB_I),
      .A_CYC_I   (A_CYC_I),
      .A_DAT_O   (A_DAT_O),
      .A_ACK_O   (A_ACK_O),
      .DAT_I     (DAT_I),
      .ACK_I     (ACK_I),
      .ADR_O     (ADR_O),
      .DAT_O     (DAT_O),
      .SEL_O     (SEL_O),
      .WE_O      (WE_O),
      .STB_O     (STB_O),
      .CYC_O     (CYC_O),
      .grant_o   (grant_o),
      .timeout_o (timeout_o)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  cyc, stb, we;
      logic        ack;
      logic [31:0] dat;
      logic [1:0]  e_grant;
      logic        e_cyc, e_stb;
      logic [1:0]  e_mux;   // which manager is mirrored on the bus (one-hot)
      logic [1:0]  e_ack;
      logic        e_tmo;
   } vec_t;

   typedef struct {
      logic [1:0]  grant, ack;
      logic        cyc, stb, tmo, we;
      logic [31:0] adr, wdat, rd0, rd1;
      logic [3:0]  sel;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic add(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                      input logic [1:0] we, input logic ack, input logic [31:0] dat,
                      input logic [1:0] e_grant, input logic e_cyc, input logic e_stb,
                      input logic [1:0] e_mux, input logic [1:0] e_ack, input logic e_tmo);
      vec_t v;
      v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack; v.dat = dat;
      v.e_grant = e_grant; v.e_cyc = e_cyc; v.e_stb = e_stb;
      v.e_mux = e_mux; v.e_ack = e_ack; v.e_tmo = e_tmo;
      vecs.push_back(v);
   endtask

   // Idle row: bus quiet, no grant, no ack.
   task automatic add_idle(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                           input logic ack, input logic [31:0] dat);
      add(rst, cyc, stb, 2'b00, ack, dat, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
   endtask

   function automatic exp_t model(input vec_t v);
      exp_t e;
      e.grant = v.e_grant;
      e.ack   = v.e_ack;
      e.cyc   = v.e_cyc;
      e.stb   = v.e_stb;
      e.tmo   = v.e_tmo;
      e.adr   = v.e_mux[0] ? ADR0 : v.e_mux[1] ? ADR1 : 32'h0;
      e.wdat  = v.e_mux[0] ? WD0  : v.e_mux[1] ? WD1  : 32'h0;
      e.sel   = v.e_mux[0] ? SEL0 : v.e_mux[1] ? SEL1 : 4'h0;
      e.we    = v.e_mux[0] ? v.we[0] : v.e_mux[1] ? v.we[1] : 1'b0;
      e.rd0   = v.e_mux[0] ? v.dat : (v.e_tmo && v.e_grant[0]) ? TDAT : 32'h0;
      e.rd1   = v.e_mux[1] ? v.dat : (v.e_tmo && v.e_grant[1]) ? TDAT : 32'h0;
      return e;
   endfunction

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      wb_rst_i = v.rst;
      A_CYC_I  = v.cyc;
      A_STB_I  = v.stb;
      A_WE_I   = v.we;
      ACK_I    = v.ack;
      DAT_I    = v.dat;
   endtask

   initial begin
      exp_t e;
      logic [1:0] oh;
      int   stall_cnt;
      bit   seen;

      A_ADR_I = {ADR1, ADR0};
      A_DAT_I = {WD1, WD0};
      A_SEL_I = {SEL1, SEL0};
      A_WE_I = 2'b00; A_STB_I = 2'b00; A_CYC_I = 2'b00;
      ACK_I = 1'b0; DAT_I = 32'h0;
      wb_rst_i = 1'b1;

      // ---- reset state (hand-written) ----
      repeat (2) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      check("rst_grant", -1, 32'(grant_o), 32'h0);
      check("rst_cyc",   -1, 32'(CYC_O), 32'h0);
      check("rst_stb",   -1, 32'(STB_O), 32'h0);
      check("rst_adr",   -1, ADR_O, 32'h0);
      check("rst_ack",   -1, 32'(A_ACK_O), 32'h0);
      check("rst_rdat",  -1, A_DAT_O[31:0] | A_DAT_O[63:32], 32'h0);
      check("rst_tmo",   -1, 32'(timeout_o), 32'h0);

      // ---- vector table ----
      // Single manager read: arbitration in one cycle, ack after two stalled cycles.
      add_idle(1'b0, 2'b01, 2'b01, 1'b0, 32'h0);
      add(0, 2'b01, 2'b01, 2'b00, 0, 32'h0,          2'b01, 1, 1, 2'b01, 2'b00, 0);
      add(0, 2'b01, 2'b01, 2'b00, 0, 32'h0,          2'b01, 1, 1, 2'b01, 2'b00, 0);
      add(0, 2'b01, 2'b01, 2'b00, 1, 32'h1234_5678,  2'b01, 1, 1, 2'b01, 2'b01, 0);
      add(0, 2'b00, 2'b00, 2'b00, 0, 32'h0,          2'b01, 0, 0, 2'b01, 2'b00, 0);
      add_idle(1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
      // Contention right after reset: M0 first, dead cycle, then M1.
      add_idle(1'b1, 2'b00, 2'b00, 1'b0, 32'h0);
      add_idle(1'b0, 2'b11, 2'b11, 1'b0, 32'h0);
      add(0, 2'b11, 2'b11, 2'b00, 0, 32'h0,          2'b01, 1, 1, 2'b01, 2'b00, 0);
      add(0, 2'b11, 2'b11, 2'b00, 1, 32'hAAAA_0001,  2'b01, 1, 1, 2'b01, 2'b01, 0);
      add(0, 2'b10, 2'b10, 2'b00, 0, 32'h0,          2'b01, 0, 0, 2'b01, 2'b00, 0);
      add_idle(1'b0, 2'b10, 2'b10, 1'b0, 32'h0);
      add(0, 2'b10, 2'b10, 2'b00, 0, 32'h0,          2'b10, 1, 1, 2'b10, 2'b00, 0);
      add(0, 2'b10, 2'b10, 2'b00, 1, 32'hBBBB_0002,  2'b10, 1, 1, 2'b10, 2'b10, 0);
      add(0, 2'b00, 2'b00, 2'b00, 0, 32'h0,          2'b10, 0, 0, 2'b10, 2'b00, 0);
      add_idle(1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
      // Fairness: both request continuously, single beats -> 0,1,0,1,0,1.
      for (int t = 0; t < 6; t++) begin
         oh = (t % 2 == 0) ? 2'b01 : 2'b10;
         add_idle(1'b0, 2'b11, 2'b11, 1'b0, 32'h0);
         add(0, 2'b11, 2'b11, 2'b00, 1, 32'h5000_0000 + 32'(t), oh, 1, 1, oh, oh, 0);
         add(0, ~oh, ~oh, 2'b00, 0, 32'h0, oh, 0, 0, oh, 2'b00, 0);
      end
      // Burst hold: M1 keeps CYC over 4 write beats while M0 waits.
      add_idle(1'b0, 2'b10, 2'b10, 1'b0, 32'h0);
      for (int b = 0; b < 4; b++) begin
         add(0, 2'b11, 2'b11, 2'b10, 1, 32'hC000_0000 + 32'(b), 2'b10, 1, 1, 2'b10, 2'b10, 0);
      end
      add(0, 2'b01, 2'b01, 2'b00, 0, 32'h0,          2'b10, 0, 0, 2'b10, 2'b00, 0);
      add_idle(1'b0, 2'b01, 2'b01, 1'b0, 32'h0);
      add(0, 2'b01, 2'b01, 2'b00, 1, 32'hD000_0001,  2'b01, 1, 1, 2'b01, 2'b01, 0);
      add(0, 2'b00, 2'b00, 2'b00, 0, 32'h0,          2'b01, 0, 0, 2'b01, 2'b00, 0);
      add_idle(1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
      // Watchdog: four stalled cycles, TMO with a late ACK discarded, back to GRANT.
      add_idle(1'b0, 2'b01, 2'b01, 1'b0, 32'h0);
      for (int s = 0; s < 4; s++) add(0, 2'b01, 2'b01, 2'b01, 0, 32'h0, 2'b01, 1, 1, 2'b01, 2'b00, 0);
      add(0, 2'b01, 2'b01, 2'b01, 1, 32'h5555_5555,  2'b01, 0, 0, 2'b00, 2'b01, 1);
      // Second timeout, with CYC dropping in the TMO cycle itself.
      for (int s = 0; s < 4; s++) add(0, 2'b01, 2'b01, 2'b01, 0, 32'h0, 2'b01, 1, 1, 2'b01, 2'b00, 0);
      add(0, 2'b00, 2'b00, 2'b00, 0, 32'h0,          2'b01, 0, 0, 2'b00, 2'b01, 1);
      add_idle(1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
      // ACK on the 4th stalled cycle wins: normal ack, no timeout.
      add_idle(1'b0, 2'b01, 2'b01, 1'b0, 32'h0);
      for (int s = 0; s < 3; s++) add(0, 2'b01, 2'b01, 2'b01, 0, 32'h0, 2'b01, 1, 1, 2'b01, 2'b00, 0);
      add(0, 2'b01, 2'b01, 2'b01, 1, 32'h6666_6666,  2'b01, 1, 1, 2'b01, 2'b01, 0);
      add(0, 2'b00, 2'b00, 2'b00, 0, 32'h0,          2'b01, 0, 0, 2'b01, 2'b00, 0);
      add_idle(1'b0, 2'b00, 2'b00, 1'b0, 32'h0);
      // Reset while M1 owns the bus; the next contended request goes to M0.
      add_idle(1'b0, 2'b10, 2'b10, 1'b0, 32'h0);
      add(0, 2'b10, 2'b10, 2'b00, 0, 32'h0,          2'b10, 1, 1, 2'b10, 2'b00, 0);
      add(1, 2'b10, 2'b10, 2'b00, 0, 32'h0,          2'b10, 1, 1, 2'b10, 2'b00, 0);
      add_idle(1'b0, 2'b11, 2'b11, 1'b1, 32'h7777_7777);
      add(0, 2'b11, 2'b11, 2'b00, 0, 32'h0,          2'b01, 1, 1, 2'b01, 2'b00, 0);
      add(0, 2'b00, 2'b00, 2'b00, 0, 32'h0,          2'b01, 0, 0, 2'b01, 2'b00, 0);
      add_idle(1'b0, 2'b00, 2'b00, 1'b0, 32'h0);

      foreach (vecs[i]) begin
         @(posedge wb_clk_i);
         #1;
         drive(vecs[i]);
         sb.push_back(model(vecs[i]));
         @(negedge wb_clk_i);
         e = sb.pop_front();
         $display("row %0d rst=%b cyc=%b ack_i=%b -> grant=%b cyc_o=%b stb_o=%b ack_o=%b tmo=%b",
                  i, vecs[i].rst, vecs[i].cyc, vecs[i].ack, grant_o, CYC_O, STB_O, A_ACK_O, timeout_o);
         check("grant", i, 32'(grant_o),   32'(e.grant));
         check("cyc_o", i, 32'(CYC_O),     32'(e.cyc));
         check("stb_o", i, 32'(STB_O),     32'(e.stb));
         check("ack_o", i, 32'(A_ACK_O),   32'(e.ack));
         check("tmo",   i, 32'(timeout_o), 32'(e.tmo));
         check("adr_o", i, ADR_O,          e.adr);
         check("dat_o", i, DAT_O,          e.wdat);
         check("sel_o", i, 32'(SEL_O),     32'(e.sel));
         check("we_o",  i, 32'(WE_O),      32'(e.we));
         check("rdat0", i, A_DAT_O[31:0],  e.rd0);
         check("rdat1", i, A_DAT_O[63:32], e.rd1);
      end

      // ---- hand sequence: M1 stalls until the watchdog fires (bounded wait) ----
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0; A_CYC_I = 2'b10; A_STB_I = 2'b10; A_WE_I = 2'b00;
      ACK_I = 1'b0; DAT_I = 32'h0;
      stall_cnt = 0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge wb_clk_i);
         if (timeout_o) seen = 1'b1;
         else if (CYC_O) stall_cnt++;
      end
      $display("watchdog seq: seen=%0d stalled=%0d ack_o=%b rdat1=%h", seen, stall_cnt, A_ACK_O, A_DAT_O[63:32]);
      check("tmo_seen",  -2, 32'(seen), 32'h1);
      check("tmo_stall", -2, 32'(stall_cnt), 32'd4);
      check("tmo_ack",   -2, 32'(A_ACK_O), 32'h2);
      check("tmo_rdat",  -2, A_DAT_O[63:32], TDAT);
      A_CYC_I = 2'b00; A_STB_I = 2'b00;
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      check("tmo_pulse", -2, 32'(timeout_o), 32'h0);
      check("tmo_idle",  -2, 32'(grant_o), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
